fifo_thresh: RTL and testbench
==============================

// Module: fifo_thresh
// PURPOSE
//  Parametrised successor to the single-port SPI FIFO: synchronous FIFO with concurrent read/write,
//  programmable almost-empty/almost-full thresholds, fill-level output, sticky overflow/underflow
//  flags and synchronous flush. Sits between the bus register file and the SPI shift engine (TX and RX).
//  First-word fall-through: data_out always presents the oldest entry.
// PARAMETERS
//  DEPTH     16  number of entries; power of two, >= 4
//  WIDTH     32  data width in bits
//  AE_LEVEL  2   almost_empty asserted while level <= AE_LEVEL (0 < AE_LEVEL < DEPTH)
//  AF_LEVEL  14  almost_full asserted while level >= AF_LEVEL (AE_LEVEL < AF_LEVEL < DEPTH)
// PORTS
//  clk           in   1                  rising-edge clock
//  reset         in   1                  asynchronous, active-low reset
//  chipselect    in   1                  qualifies read and write
//  write         in   1                  push data_in (with chipselect)
//  read          in   1                  pop head entry (with chipselect)
//  flush         in   1                  synchronous empty; not gated by chipselect
//  flag_clear    in   2                  W1C: [0] clears ovf, [1] clears udf
//  data_in       in   WIDTH              write data
//  data_out      out  WIDTH              head entry (fall-through); undefined when empty
//  level         out  $clog2(DEPTH)+1    current entry count, 0..DEPTH
//  empty, full   out  1                  level==0 / level==DEPTH
//  almost_empty  out  1                  level <= AE_LEVEL
//  almost_full   out  1                  level >= AF_LEVEL
//  ovf, udf      out  1                  sticky overflow / underflow
// BEHAVIOUR
//  - reset low (async): rp=wp=0, level=0, ovf=udf=0 => empty=1, almost_empty=1, full=0, almost_full=0.
//    Memory contents are not reset. Reset mid-operation discards all entries.
//  - rd = chipselect&read, wr = chipselect&write; evaluated on the rising edge.
//  - Priority each cycle: flush > (rd/wr). flush: rp=wp=0, level=0; rd/wr ignored that cycle;
//    ovf/udf are not changed by flush.
//  - rd only: if !empty, rp+1, level-1; if empty, no pointer change, udf<=1.
//  - wr only: if !full, mem[wp]<=data_in, wp+1, level+1; if full, data dropped, ovf<=1.
//  - rd & wr, 0<level<DEPTH: both performed, level unchanged.
//  - rd & wr, empty: write performed (level 0->1), read ignored, udf<=1.
//  - rd & wr, full: both performed (slot freed same edge), level stays DEPTH, ovf not set.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0; level is separate counter.
//  - Latency: word written into empty FIFO appears on data_out the cycle after the write edge;
//    after a pop, next entry appears on data_out the cycle after the read edge.
//  - Status outputs (empty/full/almost_*) are combinational decodes of registered level;
//    no glitch-free requirement beyond that.
//  - flag_clear[i] high clears corresponding flag; if set and clear coincide, set wins.
// TESTING
//  1. Reset, then 16 writes of 0x100+i -> level 16, full=1, almost_full=1 from 14th write;
//     16 reads return 0x100..0x10F in order, empty=1 after last.
//  2. Full FIFO, wr alone with 0xDEAD -> ovf=1, level 16, contents intact; flag_clear=2'b01 -> ovf=0.
//  3. Empty FIFO, rd&wr with 0xBEEF -> level 1, udf=1, data_out=0xBEEF next cycle.
//  4. Full FIFO, rd&wr with 0x55 for 20 cycles -> level stays 16, ovf=0, pointers wrap, order preserved.
//  5. Level 7, flush with rd&wr asserted -> level 0, empty=1, ovf/udf unchanged, no write stored.
//  6. Assert reset low asynchronously mid-burst (level 9) -> outputs at reset values without a clk edge.

Source files
------------

// File: rtl/fifo_thresh.sv
// Synchronous first-word-fall-through FIFO with programmable almost-empty/almost-full
// thresholds, a fill-level output, sticky overflow/underflow flags and a synchronous flush.
module fifo_thresh #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 32,
    parameter int AE_LEVEL = 2,
    parameter int AF_LEVEL = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic                       flush,
    input  logic [1:0]                 flag_clear,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;
    logic             rd;
    logic             wr;
    logic             do_rd;
    logic             do_wr;
    logic             ovf_set;
    logic             udf_set;

    // Transfer rule: a request is taken on the rising edge where chipselect and
    // read/write are both high; there is no back-pressure, refused requests only
    // raise ovf/udf. A full FIFO still accepts a write if a read frees a slot.
    always_comb begin
        rd      = chipselect & read;
        wr      = chipselect & write;
        do_rd   = rd & ~empty & ~flush;
        do_wr   = wr & (~full | rd) & ~flush;
        ovf_set = wr & full & ~rd & ~flush;
        udf_set = rd & empty & ~flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp    <= '0;
            wp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (flush) begin
                rp    <= '0;
                wp    <= '0;
                level <= '0;
            end else begin
                if (do_rd) rp <= rp + 1'b1;
                if (do_wr) wp <= wp + 1'b1;
                if (do_wr && !do_rd)
                    level <= level + 1'b1;
                else if (do_rd && !do_wr)
                    level <= level - 1'b1;
            end
            // Set wins over a coincident W1C clear.
            ovf <= ovf_set | (ovf & ~flag_clear[0]);
            udf <= udf_set | (udf & ~flag_clear[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= data_in;
    end

    assign data_out     = mem[rp];
    assign empty        = (level == '0);
    assign full         = (level == FULL_LVL);
    assign almost_empty = (level <= AE_LVL);
    assign almost_full  = (level >= AF_LVL);

endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_fifo_thresh;

    localparam int DEPTH    = 16;
    localparam int WIDTH    = 32;
    localparam int AE_LEVEL = 2;
    localparam int AF_LEVEL = 14;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             chipselect;
    logic             write;
    logic             read;
    logic             flush;
    logic [1:0]       flag_clear;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             ovf;
    logic             udf;

    fifo_thresh #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .AE_LEVEL(AE_LEVEL), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .flush(flush), .flag_clear(flag_clear), .data_in(data_in),
        .data_out(data_out), .level(level), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .ovf(ovf), .udf(udf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf;
    logic             m_udf;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic             cs;
        logic             wr;
        logic             rd;
        logic             fl;
        logic [1:0]       fc;
        logic [WIDTH-1:0] din;
        int               e_level;
        logic             e_dchk;
        logic [WIDTH-1:0] e_dout;
        logic             e_ovf;
        logic             e_udf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Reference rules applied once per clock edge.
    task automatic model_step(input logic cs, input logic w_in, input logic r_in,
                              input logic fl, input logic [1:0] fc, input logic [WIDTH-1:0] din);
        logic rq, wq, was_empty, was_full, os, us;
        rq = cs & r_in;
        wq = cs & w_in;
        was_empty = (exp_q.size() == 0);
        was_full  = (exp_q.size() == DEPTH);
        os = 1'b0;
        us = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (rq && was_empty) us = 1'b1;
            if (wq && was_full && !rq) os = 1'b1;
            if (rq && !was_empty) void'(exp_q.pop_front());
            if (wq && (!was_full || rq)) exp_q.push_back(din);
        end
        m_ovf = os ? 1'b1 : (fc[0] ? 1'b0 : m_ovf);
        m_udf = us ? 1'b1 : (fc[1] ? 1'b0 : m_udf);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ".level"}, WIDTH'(level), WIDTH'(n));
        chk({tag, ".empty"}, WIDTH'(empty), WIDTH'(n == 0));
        chk({tag, ".full"}, WIDTH'(full), WIDTH'(n == DEPTH));
        chk({tag, ".almost_empty"}, WIDTH'(almost_empty), WIDTH'(n <= AE_LEVEL));
        chk({tag, ".almost_full"}, WIDTH'(almost_full), WIDTH'(n >= AF_LEVEL));
        chk({tag, ".ovf"}, WIDTH'(ovf), WIDTH'(m_ovf));
        chk({tag, ".udf"}, WIDTH'(udf), WIDTH'(m_udf));
        if (n > 0) chk({tag, ".data_out"}, data_out, exp_q[0]);
    endtask

    // driver: apply inputs, take one edge, advance the model
    task automatic cycle(input logic cs, input logic w_in, input logic r_in,
                         input logic fl, input logic [1:0] fc, input logic [WIDTH-1:0] din);
        chipselect = cs;
        write      = w_in;
        read       = r_in;
        flush      = fl;
        flag_clear = fc;
        data_in    = din;
        @(posedge clk);
        #1;
        model_step(cs, w_in, r_in, fl, fc, din);
    endtask

    task automatic idle_inputs();
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        flush      = 1'b0;
        flag_clear = 2'b00;
        data_in    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic fill(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            cycle(1, 1, 0, 0, 2'b00, base + WIDTH'(i));
            check_all("fill");
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        reset = 1'b0;
        #20;
        chk("reset.level", WIDTH'(level), 0);
        chk("reset.empty", WIDTH'(empty), 1);
        chk("reset.almost_empty", WIDTH'(almost_empty), 1);
        chk("reset.full", WIDTH'(full), 0);
        chk("reset.almost_full", WIDTH'(almost_full), 0);
        chk("reset.flags", WIDTH'({ovf, udf}), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // vector table: cs wr rd fl fc din -> level, dout-check, dout, ovf, udf
        tbl[0]  = '{1, 1, 0, 0, 2'b00, 32'h11, 1, 1, 32'h11, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 2'b00, 32'h22, 2, 1, 32'h11, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 2'b00, 32'h33, 2, 1, 32'h22, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 2'b00, 32'h00, 1, 1, 32'h33, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 2'b00, 32'h00, 0, 0, 32'h00, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 2'b00, 32'h00, 0, 0, 32'h00, 0, 1};
        tbl[6]  = '{0, 1, 1, 0, 2'b00, 32'h44, 0, 0, 32'h00, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 2'b10, 32'h00, 0, 0, 32'h00, 0, 0};
        tbl[8]  = '{1, 1, 1, 0, 2'b00, 32'h55, 1, 1, 32'h55, 0, 1};
        tbl[9]  = '{1, 0, 1, 0, 2'b10, 32'h00, 0, 0, 32'h00, 0, 0};
        tbl[10] = '{1, 0, 1, 0, 2'b10, 32'h00, 0, 0, 32'h00, 0, 1};
        tbl[11] = '{1, 1, 0, 1, 2'b00, 32'h66, 0, 0, 32'h00, 0, 1};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].cs, tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].fc, tbl[i].din);
            chk($sformatf("vec%0d.level", i), WIDTH'(level), WIDTH'(tbl[i].e_level));
            chk($sformatf("vec%0d.ovf", i), WIDTH'(ovf), WIDTH'(tbl[i].e_ovf));
            chk($sformatf("vec%0d.udf", i), WIDTH'(udf), WIDTH'(tbl[i].e_udf));
            if (tbl[i].e_dchk) chk($sformatf("vec%0d.data_out", i), data_out, tbl[i].e_dout);
        end

        // 16 writes then 16 in-order reads
        do_reset();
        fill(16, 32'h100);
        chk("t1.full", WIDTH'(full), 1);
        for (int i = 0; i < 16; i++) begin
            chk("t1.order", data_out, 32'h100 + WIDTH'(i));
            cycle(1, 0, 1, 0, 2'b00, '0);
            check_all("t1.read");
        end
        chk("t1.empty", WIDTH'(empty), 1);

        // overflow on full, contents intact, W1C clear
        fill(16, 32'h200);
        cycle(1, 1, 0, 0, 2'b00, 32'hDEAD);
        check_all("t2.ovf");
        chk("t2.ovf_set", WIDTH'(ovf), 1);
        cycle(0, 0, 0, 0, 2'b01, '0);
        check_all("t2.clr");
        for (int i = 0; i < 16; i++) begin
            chk("t2.intact", data_out, 32'h200 + WIDTH'(i));
            cycle(1, 0, 1, 0, 2'b00, '0);
        end
        check_all("t2.drained");

        // rd&wr on empty
        cycle(1, 1, 1, 0, 2'b00, 32'hBEEF);
        check_all("t3");
        chk("t3.data_out", data_out, 32'hBEEF);
        chk("t3.udf", WIDTH'(udf), 1);
        cycle(0, 0, 0, 0, 2'b10, '0);
        check_all("t3.clr");

        // full rd&wr streaming, pointers wrap
        do_reset();
        fill(16, 32'h300);
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, 1, 0, 2'b00, 32'h55 + WIDTH'(k));
            check_all("t4.stream");
        end
        chk("t4.level", WIDTH'(level), 16);

        // flush overrides rd&wr, flags unchanged
        do_reset();
        cycle(1, 0, 1, 0, 2'b00, '0);
        fill(7, 32'h400);
        cycle(1, 1, 1, 1, 2'b00, 32'h777);
        check_all("t5.flush");
        chk("t5.udf_kept", WIDTH'(udf), 1);
        cycle(0, 0, 0, 0, 2'b00, '0);
        check_all("t5.after");

        // asynchronous reset mid-burst
        fill(9, 32'h500);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        chk("t6.level", WIDTH'(level), 0);
        #1;
        reset = 1'b1;
        #1;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                  $urandom);
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
